alu_issue_seq: RTL
==================

# alu_issue_seq

Multicycle issue sequencer that sits directly upstream of the 9-bit ALU and feeds it. It accepts one instruction at a time over a valid/ready handshake. It reads operands from a 4-entry × 9-bit register file, presents opcode and operands to the ALU, and writes the ALU result back. It stops permanently on the halt opcode, so the ALU never receives opcode 4'b1111.

## Interface
- NREGS, 4, register-file entries; fixed, sets the 2-bit register fields
- DW, 9, datapath width; matches the ALU
- clk  in  1  sole clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- instr_valid  in  1  instr holds an instruction
- instr  in  17  fields:
  - [16:13] opcode
  - [12:11] rd
  - [10:9] ra
  - [8:0] imm9 when opcode=4'b1010; otherwise [1:0] is rb and [8:2] is ignored
- instr_ready  out  1  sequencer can accept an instruction
- alu_opcode  out  4  to ALU opcode
- alu_a  out  9  to ALU a
- alu_b  out  9  to ALU b
- alu_result  in  9  from ALU out (combinational in ALU)
- wb_valid  out  1  one-cycle pulse: register written this edge
- wb_reg  out  2  register written
- wb_data  out  9  value written
- halted  out  1  halt opcode accepted
- retired  out  8  count of retired non-halt instructions; wraps
- dbg_sel  in  2  register-file debug read select
- dbg_data  out  9  combinational read of reg[dbg_sel]

## Operation
- States: IDLE, READ, EXEC, HALT. Reset enters IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready: latch instr into IR.
  - If opcode=4'b1111, go to HALT. Otherwise go to READ.
- READ:
  - Register alu_opcode←IR.opcode and alu_a←reg[ra].
  - alu_b←imm9 if opcode=4'b1010, else reg[rb].
  - Go to EXEC.
- EXEC:
  - alu_result is valid for the whole cycle.
  - At the edge:
    - Opcode 4'b1011 (no-op): no write; wb_valid stays 0.
    - All other opcodes, including undefined 4'b1100–4'b1110 (ALU returns 0): reg[rd]←alu_result, wb_valid=1, wb_reg=rd, wb_data=alu_result.
  - retired increments by 1 for both cases.
  - Return to IDLE and restore alu_opcode to the idle value 4'b0100.
- HALT:
  - halted=1 and instr_ready=0 until reset.
  - Input is ignored; registers and retired are frozen.
  - alu_opcode stays 4'b0100.
- Operand source is 9-bit unsigned; no sign or width conversion. The sequencer does no arithmetic apart from retired, which wraps 255→0.
- Same register as source and destination (rd=ra): the old value is read in READ, and the new value is written at the end of EXEC.
- dbg_data reflects a write from the cycle after the write edge.
- instr_valid may drop while instr_ready=0 with no effect. instr must be stable only while instr_valid&instr_ready=1.

## Timing
- Reset values:
  - instr_ready=1
  - alu_opcode=4'b0100, alu_a=0, alu_b=0
  - wb_valid=0, wb_reg=0, wb_data=0
  - halted=0, retired=0
  - all registers 0
- Throughput: one instruction per 3 cycles (IDLE→READ→EXEC). Back-to-back accept is possible in the cycle after EXEC.
- Latency: accept edge T → ALU inputs valid T+1..T+2 → write edge at T+2. wb_valid is high in the cycle following that edge.
- wb_valid is exactly 1 cycle wide. wb_reg and wb_data hold their values until the next write.
- Reset asserted mid-operation aborts the instruction with no write, and all outputs take their reset values immediately. After deassertion, the first edge sees IDLE.

## Test plan
- Reset, then load immediates:
  - Stimulus: 1010 rd=1 imm=9'h0A5; then 1010 rd=2 imm=9'h15B.
  - Required: wb pulses (1,0A5) then (2,15B); dbg_sel=1 → 0A5; retired=2; ready low exactly 2 of every 3 cycles.
- ALU ops with r1=0A5, r2=15B:
  - 1000 rd=3 ra=1 rb=2 → r3=9'h000 (carry dropped).
  - 1001 rd=0 ra=2 rb=1 → r0=9'h0B6.
  - 0101 rd=3 ra=1 → r3=9'h14A.
  - During EXEC, alu_a/alu_b/alu_opcode match the selected registers.
- No-op and undefined:
  - 1011 → retired increments, wb_valid never asserts.
  - 1100 rd=2 → r2=0.
- Halt:
  - Stimulus: 1111, then more valid instructions.
  - Required: halted=1 next cycle; ready stays 0; alu_opcode never shows 1111; registers and retired unchanged.
- Reset mid-instruction:
  - Stimulus: assert reset in EXEC of 0000 rd=1.
  - Required: no write; all outputs at reset values asynchronously; normal accept afterward.
- Wrap: 256 no-ops → retired returns to 0.

Source files
------------

// File: rtl/alu_issue_seq.sv
// Multicycle issue sequencer for the 9-bit ALU: accept -> operand read -> execute/writeback.
// Owns the 4-entry register file and halts permanently on opcode 4'b1111.
module alu_issue_seq #(
    parameter int NREGS = 4,
    parameter int DW    = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    input  logic [16:0]   instr,
    output logic          instr_ready,
    output logic [3:0]    alu_opcode,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    output logic          wb_valid,
    output logic [1:0]    wb_reg,
    output logic [DW-1:0] wb_data,
    output logic          halted,
    output logic [7:0]    retired,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    localparam logic [3:0] OP_IDLE = 4'b0100;
    localparam logic [3:0] OP_IMM  = 4'b1010;
    localparam logic [3:0] OP_NOP  = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1111;

    logic [1:0]    state_q, state_d;
    logic [16:0]   ir_q, ir_d;
    logic [DW-1:0] regs_q [NREGS];
    logic          reg_we;
    logic [3:0]    alu_opcode_q, alu_opcode_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic          wb_valid_q, wb_valid_d;
    logic [1:0]    wb_reg_q, wb_reg_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic          halted_q, halted_d;
    logic [7:0]    retired_q, retired_d;

    logic [3:0] ir_op;
    logic [1:0] ir_rd;
    logic [1:0] ir_ra;
    logic [1:0] ir_rb;
    logic [8:0] ir_imm;

    assign ir_op  = ir_q[16:13];
    assign ir_rd  = ir_q[12:11];
    assign ir_ra  = ir_q[10:9];
    assign ir_rb  = ir_q[1:0];
    assign ir_imm = ir_q[8:0];

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both high; instr_ready is high only in IDLE.
    assign instr_ready = (state_q == S_IDLE);

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        wb_valid_d   = 1'b0;
        wb_reg_d     = wb_reg_q;
        wb_data_d    = wb_data_q;
        halted_d     = halted_q;
        retired_d    = retired_q;
        reg_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_d = instr;
                    if (instr[16:13] == OP_HALT) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                alu_opcode_d = ir_op;
                alu_a_d      = regs_q[ir_ra];
                alu_b_d      = (ir_op == OP_IMM) ? ir_imm : regs_q[ir_rb];
                state_d      = S_EXEC;
            end
            S_EXEC: begin
                if (ir_op != OP_NOP) begin
                    reg_we     = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_reg_d   = ir_rd;
                    wb_data_d  = alu_result;
                end
                retired_d    = retired_q + 8'd1;
                alu_opcode_d = OP_IDLE;
                state_d      = S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ir_q         <= '0;
            alu_opcode_q <= OP_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            wb_valid_q   <= 1'b0;
            wb_reg_q     <= '0;
            wb_data_q    <= '0;
            halted_q     <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            wb_valid_q   <= wb_valid_d;
            wb_reg_q     <= wb_reg_d;
            wb_data_q    <= wb_data_d;
            halted_q     <= halted_d;
            retired_q    <= retired_d;
        end
    end

    // Register file: operands are sampled in READ, so rd==ra sees the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[ir_rd] <= alu_result;
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign wb_valid   = wb_valid_q;
    assign wb_reg     = wb_reg_q;
    assign wb_data    = wb_data_q;
    assign halted     = halted_q;
    assign retired    = retired_q;
    assign dbg_data   = regs_q[dbg_sel];

endmodule
